// File: rtl/fft_agu_pkg.sv
// ---------------------------------------------------------------------------
// fft_agu_pkg
// Shared types and helpers for the radix-2 in-place FFT address sequencer.
//   agu_state_t  : sequencer states (IDLE, RUN, DRAIN, DONE)
//   STAGE_W      : stage index width for the default 8192-point build
//   stage_mask() : (1<<stage)-1, limited to addr_width bits
// ---------------------------------------------------------------------------
package fft_agu_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 13;
    localparam int unsigned STAGE_W        = $clog2(DEF_ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } agu_state_t;

    // Low-bit mask selecting the position of an address inside its butterfly
    // group for the given stage.
    function automatic logic [31:0] stage_mask(input logic [31:0] stage,
                                               input int unsigned addr_width);
        logic [31:0] m;
        m = (32'd1 << stage) - 32'd1;
        if (addr_width < 32) begin
            m = m & ((32'd1 << addr_width) - 32'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/fft_agu_addr_step.sv
// ---------------------------------------------------------------------------
// fft_agu_addr_step
// Combinational address arithmetic for one butterfly pair.
// Ports:
//   i_addr_a          : current upper-wing (even) address
//   i_stage           : current stage
//   o_next_addr_a     : addr_a of the following pair in the same stage
//   o_addr_b          : lower-wing partner, i_addr_a | (1<<stage)
//   o_tw_idx          : twiddle ROM index
//   o_last_in_stage   : this pair is the final one of its stage
// ---------------------------------------------------------------------------
module fft_agu_addr_step
    import fft_agu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic [ADDR_WIDTH-1:0]         i_addr_a,
    input  logic [$clog2(ADDR_WIDTH)-1:0] i_stage,
    output logic [ADDR_WIDTH-1:0]         o_next_addr_a,
    output logic [ADDR_WIDTH-1:0]         o_addr_b,
    output logic [ADDR_WIDTH-2:0]         o_tw_idx,
    output logic                          o_last_in_stage
);

    localparam int unsigned LP_STAGE_W = $clog2(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] w_bit;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_low;
    logic [ADDR_WIDTH-1:0] w_tw_full;
    logic [LP_STAGE_W-1:0] w_shamt;
    logic                  w_jump;

    assign w_bit  = ADDR_WIDTH'(1) << i_stage;
    assign w_mask = ADDR_WIDTH'(stage_mask(32'(i_stage), ADDR_WIDTH));
    assign w_low  = i_addr_a & w_mask;

    // Compared against the mask rather than AND-reduced so stage 0 (empty
    // mask) always jumps over its partner.
    assign w_jump = (w_low == w_mask);

    assign o_next_addr_a   = i_addr_a + ADDR_WIDTH'(1) + (w_jump ? w_bit : '0);
    assign o_addr_b        = i_addr_a | w_bit;
    assign o_last_in_stage = &o_addr_b;

    assign w_shamt   = LP_STAGE_W'(ADDR_WIDTH - 1) - i_stage;
    assign w_tw_full = w_low << w_shamt;
    assign o_tw_idx  = (ADDR_WIDTH-1)'(w_tw_full);

endmodule

// File: rtl/fft_agu_seq.sv
// ---------------------------------------------------------------------------
// fft_agu_seq
// Stage/butterfly sequencer for a shared radix-2 in-place FFT datapath.
// Walks all ADDR_WIDTH stages, issuing N/2 address pairs plus a twiddle
// index per stage over a valid/ready handshake, with BF_LATENCY idle
// cycles between stages so the butterfly can retire its writes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle run request, honoured only when idle
//   busy, done      : run in progress / one-cycle completion pulse
//   out_valid       : pair outputs are valid
//   out_ready       : butterfly accepts the current pair
//   addr_a, addr_b  : even / odd wing addresses
//   tw_idx          : twiddle ROM index
//   stage           : current stage
//   last_in_stage   : current pair closes its stage
// Optional (macro FFT_AGU_INV_EN):
//   inverse         : latched when start is accepted
//   tw_conj         : latched inverse while out_valid, else 0
// ---------------------------------------------------------------------------
module fft_agu_seq
    import fft_agu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned BF_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef FFT_AGU_INV_EN
    input  logic                          inverse,
    output logic                          tw_conj,
`endif
    output logic [ADDR_WIDTH-1:0]         addr_a,
    output logic [ADDR_WIDTH-1:0]         addr_b,
    output logic [ADDR_WIDTH-2:0]         tw_idx,
    output logic [$clog2(ADDR_WIDTH)-1:0] stage,
    output logic                          last_in_stage
);

    localparam int unsigned LP_STAGE_W    = $clog2(ADDR_WIDTH);
    localparam int unsigned LP_CNT_W      = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam int unsigned LP_DRAIN_LAST = (BF_LATENCY > 0) ? BF_LATENCY - 1 : 0;

    agu_state_t            r_state;
    agu_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [LP_STAGE_W-1:0] r_stage;
    logic [LP_STAGE_W-1:0] w_stage_nxt;
    logic [LP_CNT_W-1:0]   r_cnt;
    logic [LP_CNT_W-1:0]   w_cnt_nxt;

    logic [ADDR_WIDTH-1:0] w_step_addr;
    logic [ADDR_WIDTH-1:0] w_addr_b;
    logic [ADDR_WIDTH-2:0] w_tw_idx;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_accept;
    logic                  w_final_stage;

    fft_agu_addr_step #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_step (
        .i_addr_a        (r_addr_a),
        .i_stage         (r_stage),
        .o_next_addr_a   (w_step_addr),
        .o_addr_b        (w_addr_b),
        .o_tw_idx        (w_tw_idx),
        .o_last_in_stage (w_last)
    );

    assign w_valid       = (r_state == RUN);
    assign w_accept      = w_valid && out_ready;
    assign w_final_stage = (r_stage == LP_STAGE_W'(ADDR_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr_a <= '0;
            r_stage  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr_a <= w_addr_nxt;
            r_stage  <= w_stage_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr_a;
        w_stage_nxt = r_stage;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_addr_nxt  = '0;
                    w_stage_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (w_accept) begin
                    if (!w_last) begin
                        w_addr_nxt = w_step_addr;
                    end else if (w_final_stage) begin
                        w_state_nxt = DONE;
                    end else if (BF_LATENCY > 0) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_stage_nxt = r_stage + LP_STAGE_W'(1);
                        w_addr_nxt  = '0;
                    end
                end
            end
            DRAIN: begin
                if (r_cnt == LP_CNT_W'(LP_DRAIN_LAST)) begin
                    w_state_nxt = RUN;
                    w_stage_nxt = r_stage + LP_STAGE_W'(1);
                    w_addr_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_stage_nxt = '0;
                w_addr_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pair outputs are forced to zero outside RUN so an idle sequencer
    // presents an all-zero bus.
    assign out_valid     = w_valid;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign addr_a        = w_valid ? r_addr_a : '0;
    assign addr_b        = w_valid ? w_addr_b : '0;
    assign tw_idx        = w_valid ? w_tw_idx : '0;
    assign last_in_stage = w_valid & w_last;
    assign stage         = r_stage;

`ifdef FFT_AGU_INV_EN
    logic r_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_inv <= inverse;
        end
    end

    assign tw_conj = w_valid & r_inv;
`endif

endmodule

// File: tb/tb_fft_agu_seq.sv
// ---------------------------------------------------------------------------
// tb_fft_agu_seq
// Three sequencer instances share one clock:
//   0: ADDR_WIDTH=3,  BF_LATENCY=2
//   1: ADDR_WIDTH=3,  BF_LATENCY=0
//   2: ADDR_WIDTH=13, BF_LATENCY=4
// The reference pair list is built by enumerating, for every stage s, all
// addresses with bit s clear in ascending order.
// ---------------------------------------------------------------------------
module tb_fft_agu_seq;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [12:0] a;
        logic [12:0] b;
        logic [11:0] tw;
        logic [3:0]  st;
        logic        last;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [NDUT];
    logic        start_v [NDUT];
    logic        ready_v [NDUT];
    logic        inv_v   [NDUT];
    logic        m_busy  [NDUT];
    logic        m_done  [NDUT];
    logic        m_valid [NDUT];
    logic        m_last  [NDUT];
    logic        m_conj  [NDUT];
    logic [12:0] m_a     [NDUT];
    logic [12:0] m_b     [NDUT];
    logic [11:0] m_tw    [NDUT];
    logic [3:0]  m_st    [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    pair_t exp_q[$];

    logic [2:0]  a_a, a_b, z_a, z_b;
    logic [1:0]  a_tw, a_st, z_tw, z_st;
    logic [12:0] w_a, w_b;
    logic [11:0] w_tw;
    logic [3:0]  w_st;

    fft_agu_seq #(.ADDR_WIDTH(3), .BF_LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(m_busy[0]), .done(m_done[0]),
        .out_valid(m_valid[0]), .out_ready(ready_v[0]),
`ifdef FFT_AGU_INV_EN
        .inverse(inv_v[0]), .tw_conj(m_conj[0]),
`endif
        .addr_a(a_a), .addr_b(a_b), .tw_idx(a_tw), .stage(a_st), .last_in_stage(m_last[0])
    );

    fft_agu_seq #(.ADDR_WIDTH(3), .BF_LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(m_busy[1]), .done(m_done[1]),
        .out_valid(m_valid[1]), .out_ready(ready_v[1]),
`ifdef FFT_AGU_INV_EN
        .inverse(inv_v[1]), .tw_conj(m_conj[1]),
`endif
        .addr_a(z_a), .addr_b(z_b), .tw_idx(z_tw), .stage(z_st), .last_in_stage(m_last[1])
    );

    fft_agu_seq #(.ADDR_WIDTH(13), .BF_LATENCY(4)) u_dut_w (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(m_busy[2]), .done(m_done[2]),
        .out_valid(m_valid[2]), .out_ready(ready_v[2]),
`ifdef FFT_AGU_INV_EN
        .inverse(inv_v[2]), .tw_conj(m_conj[2]),
`endif
        .addr_a(w_a), .addr_b(w_b), .tw_idx(w_tw), .stage(w_st), .last_in_stage(m_last[2])
    );

`ifndef FFT_AGU_INV_EN
    assign m_conj[0] = 1'b0;
    assign m_conj[1] = 1'b0;
    assign m_conj[2] = 1'b0;
`endif

    assign m_a[0]  = {10'd0, a_a};
    assign m_b[0]  = {10'd0, a_b};
    assign m_tw[0] = {10'd0, a_tw};
    assign m_st[0] = {2'd0, a_st};
    assign m_a[1]  = {10'd0, z_a};
    assign m_b[1]  = {10'd0, z_b};
    assign m_tw[1] = {10'd0, z_tw};
    assign m_st[1] = {2'd0, z_st};
    assign m_a[2]  = w_a;
    assign m_b[2]  = w_b;
    assign m_tw[2] = w_tw;
    assign m_st[2] = w_st;

    task automatic build_model(input int aw);
        pair_t e;
        int    k;
        exp_q.delete();
        for (int s = 0; s < aw; s++) begin
            k = 0;
            for (int a = 0; a < (1 << aw); a++) begin
                if (((a >> s) & 1) == 0) begin
                    e.a    = 13'(a);
                    e.b    = 13'(a + (1 << s));
                    e.tw   = 12'((a % (1 << s)) << (aw - 1 - s));
                    e.st   = 4'(s);
                    e.last = (k == (1 << aw) / 2 - 1);
                    exp_q.push_back(e);
                    k++;
                end
            end
        end
    endtask

    // Runs one complete FFT on instance id, starting in the current cycle
    // (caller is positioned just after a falling edge with the DUT idle).
    // Returns one cycle after the done pulse, again at a falling edge.
    task automatic run_fft(input int id, input int aw, input int lat, input int rdy_pct,
                           input int stall_pair, input int spur_a, input int spur_b,
                           input logic inv);
        int    cyc, acc, gap, stall_left, extra, base_done, budget, total;
        logic  gap_on, want_done, finished, rdy, exp_c;
        pair_t e, got;
        build_model(aw);
        total     = exp_q.size();
        base_done = total + lat * (aw - 1) + 1;
        budget    = base_done * 4 + 50;
`ifdef FFT_AGU_INV_EN
        exp_c = inv;
`else
        exp_c = 1'b0;
`endif
        n_checks++;
        if (m_busy[id] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start dut=%0d got busy=%b expected 0", id, m_busy[id]);
        end
        start_v[id] = 1'b1;
        inv_v[id]   = inv;
        ready_v[id] = 1'($urandom_range(0, 1));
        cyc = 0; acc = 0; gap = 0; stall_left = 3; extra = 0;
        gap_on = 1'b0; want_done = 1'b0; finished = 1'b0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start_v[id] = (cyc == spur_a) || (cyc == spur_b);
            inv_v[id]   = 1'($urandom_range(0, 1));
            if (cyc > budget) begin
                n_checks++; n_fail++;
                $display("FAIL timeout dut=%0d cycle=%0d accepts=%0d expected %0d", id, cyc, acc, total);
                finished = 1'b1;
            end else if (want_done) begin
                n_checks++;
                if ({m_done[id], m_busy[id], m_valid[id]} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL done_pulse dut=%0d cycle=%0d got done,busy,valid=%b%b%b expected 110",
                             id, cyc, m_done[id], m_busy[id], m_valid[id]);
                end
                if (rdy_pct == 100) begin
                    n_checks++;
                    if (cyc != base_done + extra) begin
                        n_fail++;
                        $display("FAIL done_cycle dut=%0d got %0d expected %0d", id, cyc, base_done + extra);
                    end
                end
                @(negedge clk);
                cyc++;
                start_v[id] = 1'b0;
                n_checks++;
                if ({m_done[id], m_busy[id], m_valid[id]} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL after_done dut=%0d cycle=%0d got done,busy,valid=%b%b%b expected 000",
                             id, cyc, m_done[id], m_busy[id], m_valid[id]);
                end
                finished = 1'b1;
            end else begin
                n_checks++;
                if (m_done[id] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_done dut=%0d cycle=%0d got 1 expected 0", id, cyc);
                end
                if (cyc == 1) begin
                    n_checks++;
                    if (m_valid[id] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL start_latency dut=%0d got valid=%b expected 1", id, m_valid[id]);
                    end
                end
                if (m_valid[id] === 1'b1) begin
                    if (gap_on) begin
                        n_checks++;
                        if (gap != lat) begin
                            n_fail++;
                            $display("FAIL drain_len dut=%0d cycle=%0d got %0d expected %0d", id, cyc, gap, lat);
                        end
                        gap_on = 1'b0;
                    end
                    e   = exp_q[0];
                    got = {m_a[id], m_b[id], m_tw[id], m_st[id], m_last[id]};
                    n_checks++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL pair dut=%0d cycle=%0d got a=%0d b=%0d tw=%0d st=%0d last=%b expected a=%0d b=%0d tw=%0d st=%0d last=%b",
                                 id, cyc, got.a, got.b, got.tw, got.st, got.last, e.a, e.b, e.tw, e.st, e.last);
                    end
                    n_checks++;
                    if (m_conj[id] !== exp_c) begin
                        n_fail++;
                        $display("FAIL tw_conj dut=%0d cycle=%0d got %b expected %b", id, cyc, m_conj[id], exp_c);
                    end
                    if (stall_pair == acc && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                        extra++;
                    end else begin
                        rdy = ($urandom_range(1, 100) <= rdy_pct);
                    end
                    ready_v[id] = rdy;
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        acc++;
                        if (e.last) begin
                            if (exp_q.size() == 0) want_done = 1'b1;
                            else begin
                                gap_on = 1'b1;
                                gap    = 0;
                            end
                        end
                    end
                end else begin
                    ready_v[id] = 1'($urandom_range(0, 1));
                    n_checks++;
                    if (m_busy[id] !== 1'b1 || m_conj[id] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bubble_flags dut=%0d cycle=%0d got busy=%b conj=%b expected busy=1 conj=0",
                                 id, cyc, m_busy[id], m_conj[id]);
                    end
                    if (gap_on) gap++;
                    else begin
                        n_checks++; n_fail++;
                        $display("FAIL bubble dut=%0d cycle=%0d got valid=0 expected 1", id, cyc);
                    end
                end
            end
        end
        n_checks++;
        if (acc != total) begin
            n_fail++;
            $display("FAIL accept_count dut=%0d got %0d expected %0d", id, acc, total);
        end
    endtask

    task automatic test_reset();
        pair_t got;
        for (int i = 0; i < NDUT; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; ready_v[i] = 1'b0; inv_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            got = {m_a[i], m_b[i], m_tw[i], m_st[i], m_last[i]};
            n_checks++;
            if ({m_busy[i], m_done[i], m_valid[i], m_conj[i]} !== 4'b0000 || got !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d got flags=%b%b%b%b bus=%h expected all 0",
                         i, m_busy[i], m_done[i], m_valid[i], m_conj[i], got);
            end
            rst_v[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (m_busy[i] !== 1'b0 || m_valid[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset dut=%0d got busy=%b valid=%b expected 0 0", i, m_busy[i], m_valid[i]);
            end
        end
    endtask

    task automatic test_full_run();
        run_fft(0, 3, 2, 100, -1, -1, -1, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_backpressure();
        run_fft(0, 3, 2, 100, 5, -1, -1, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_random_ready();
        repeat (3) run_fft(0, 3, 2, 60, -1, -1, -1, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_no_drain();
        run_fft(1, 3, 0, 100, -1, -1, -1, 1'b1);
        run_fft(1, 3, 0, 50, -1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_fft(0, 3, 2, 100, -1, 3, 17, 1'b1);
        run_fft(0, 3, 2, 100, -1, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        pair_t got;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (c == 9) rst_v[0] = 1'b1;
        end
        @(negedge clk);
        rst_v[0] = 1'b0;
        got = {m_a[0], m_b[0], m_tw[0], m_st[0], m_last[0]};
        n_checks++;
        if ({m_busy[0], m_done[0], m_valid[0], m_conj[0]} !== 4'b0000 || got !== '0) begin
            n_fail++;
            $display("FAIL mid_reset dut=0 got flags=%b%b%b%b bus=%h expected all 0",
                     m_busy[0], m_done[0], m_valid[0], m_conj[0], got);
        end
        repeat (8) begin
            @(negedge clk);
            n_checks++;
            if (m_done[0] !== 1'b0 || m_busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet dut=0 got done=%b busy=%b expected 0 0", m_done[0], m_busy[0]);
            end
        end
        run_fft(0, 3, 2, 100, -1, -1, -1, 1'b1);
    endtask

    task automatic test_wide();
        run_fft(2, 13, 4, 100, -1, -1, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_random_ready();
        test_no_drain();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
